// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus interface.
// Bundles the signals exchanged between the fetch sequencer and its neighbours:
//   pc, stall, br_valid, br_target             : inputs to the sequencer
//                                                (IFU PC, hazard unit, decode stage)
//   next_pc, pc_en                             : IFU nextPC / En controls
//   fault, fault_addr, fetch_cnt, stall_cnt    : status and performance counters
// The master modport is the environment side; the slave modport is the sequencer.
interface fetch_sequencer_if;
  logic [31:0] pc;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  modport master (
    output pc, stall, br_valid, br_target,
    input  next_pc, pc_en, fault, fault_addr, fetch_cnt, stall_cnt
  );

  modport slave (
    input  pc, stall, br_valid, br_target,
    output next_pc, pc_en, fault, fault_addr, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-PC and fetch-enable controller for the instruction fetch unit.
// Chooses each cycle between sequential fall-through, an immediate decode-stage
// redirect, or a redirect held across a stall. Illegal fetch targets halt fetch
// with a sticky fault until reset. Also counts fetch and stall cycles.
// Ports:
//   clk    : system clock, rising-edge
//   reset  : asynchronous, active-high; clears all state and forces the
//            fetch controls to RESET_PC / disabled while asserted
//   bus    : fetch_sequencer_if.slave (see the interface file for signals)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pend_target, pend_target_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic [31:0] cand;
  logic [31:0] next_pc;
  logic        pc_en;

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= RESET_PC) && (addr <= LAST_PC);
  endfunction

  // A fresh redirect always beats a held one; fall-through only applies in RUN.
  always_comb begin
    if (bus.br_valid)      cand = bus.br_target;
    else if (state == PEND) cand = pend_target;
    else                    cand = bus.pc + 32'd4;
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state;
    pend_target_d = pend_target;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    next_pc       = bus.pc;
    pc_en         = 1'b0;

    if (reset) begin
      // Reset is asynchronous, so the fetch controls must follow it immediately
      // rather than waiting for the registers to settle.
      next_pc = RESET_PC;
    end else begin
      unique case (state)
        RUN, PEND: begin
          if (!bus.stall) begin
            if (is_legal(cand)) begin
              next_pc = cand;
              pc_en   = 1'b1;
              state_d = RUN;
            end else begin
              state_d      = HALT;
              fault_d      = 1'b1;
              fault_addr_d = cand;
            end
          end else if (bus.br_valid) begin
            // Stalled redirects are only recorded; they are applied once the
            // stall drops. A later redirect overwrites an earlier one.
            if (is_legal(bus.br_target)) begin
              pend_target_d = bus.br_target;
              state_d       = PEND;
            end else begin
              state_d      = HALT;
              fault_d      = 1'b1;
              fault_addr_d = bus.br_target;
            end
          end
        end
        default: ; // HALT: fetch frozen until reset
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      pend_target  <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state        <= state_d;
      pend_target  <= pend_target_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      if (pc_en)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.stall && state != HALT)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.next_pc    = next_pc;
  assign bus.pc_en      = pc_en;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
